alu_status_reader: RTL and testbench

Consumer side of the ALU's packed result/status register. Accepts the 35-bit word {overflow, zero, carry, d} captured at the ALU output, buffers it in a small FIFO, and presents the unpacked fields to downstream logic over a valid/ready handshake. It also maintains sticky overflow/carry flags, a saturating overflow event counter, and a consistency check on the zero flag.

---
 rtl/alu_status_reader_if.sv | 40 ++++
 rtl/alu_status_reader.sv | 122 ++++++++++++
 tb/tb_alu_status_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_status_reader_if.sv
// Stream and status bundle between the ALU result producer, the status reader and its consumer.
// Latency: none; this is wiring only.
// Backpressure: carries in_ready/out_ready for the valid/ready handshakes on both sides.
interface alu_status_reader_if #(
    parameter int width = 32,
    parameter int depth = 4
);
    // Producer side: packed {overflow, zero, carry, d}
    logic [width+2:0]         in_word;
    logic                     in_valid;
    logic                     in_ready;

    // Consumer side: unpacked head entry
    logic [width-1:0]         out_d;
    logic                     out_overflow;
    logic                     out_zero;
    logic                     out_carry;
    logic                     out_valid;
    logic                     out_ready;

    // Occupancy and statistics
    logic [$clog2(depth):0]   count;
    logic                     sticky_overflow;
    logic                     sticky_carry;
    logic [7:0]               ovf_count;
    logic                     err_zero;
    logic                     clear_sticky;

    modport slave (
        input  in_word, in_valid, out_ready, clear_sticky,
        output in_ready, out_d, out_overflow, out_zero, out_carry, out_valid,
               count, sticky_overflow, sticky_carry, ovf_count, err_zero
    );

    modport master (
        output in_word, in_valid, out_ready, clear_sticky,
        input  in_ready, out_d, out_overflow, out_zero, out_carry, out_valid,
               count, sticky_overflow, sticky_carry, ovf_count, err_zero
    );
endinterface

// File: rtl/alu_status_reader.sv
// Buffers packed ALU result/status words in a show-ahead FIFO and tracks sticky flag statistics on pop.
// Latency: a word accepted at edge N is visible on the outputs from edge N (1 cycle input to output).
// Backpressure: in_ready = !full from registered count only; the head is held while out_ready is low.
module alu_status_reader #(
    parameter int width = 32,   // data field width
    parameter int depth = 4     // FIFO entries, power of two, >= 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_status_reader_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int WW = width + 3;

    // Storage and pointers
    logic [WW-1:0] mem_q [depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Statistics
    logic          sticky_ovf_q, sticky_ovf_d;
    logic          sticky_carry_q, sticky_carry_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          err_zero_q, err_zero_d;

    logic          full, empty, push, pop;
    logic [WW-1:0] head;
    logic [width-1:0] head_d;
    logic          head_ovf, head_zero, head_carry;

    assign full  = (count_q == CW'(depth));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    // Show-ahead read: the head entry drives the outputs directly
    assign head       = mem_q[rd_ptr_q];
    assign head_d     = head[width-1:0];
    assign head_carry = head[width];
    assign head_zero  = head[width+1];
    assign head_ovf   = head[width+2];

    assign bus.in_ready        = !full;
    assign bus.out_valid       = !empty;
    assign bus.out_d           = head_d;
    assign bus.out_overflow    = head_ovf;
    assign bus.out_zero        = head_zero;
    assign bus.out_carry       = head_carry;
    assign bus.count           = count_q;
    assign bus.sticky_overflow = sticky_ovf_q;
    assign bus.sticky_carry    = sticky_carry_q;
    assign bus.ovf_count       = ovf_cnt_q;
    assign bus.err_zero        = err_zero_q;

    // Next pointer/occupancy state and statistics; clear is applied before the popped word's events
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sticky_ovf_d   = sticky_ovf_q;
        sticky_carry_d = sticky_carry_q;
        ovf_cnt_d      = ovf_cnt_q;
        err_zero_d     = err_zero_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (bus.clear_sticky) begin
            sticky_ovf_d   = 1'b0;
            sticky_carry_d = 1'b0;
            ovf_cnt_d      = 8'd0;
            err_zero_d     = 1'b0;
        end

        if (pop) begin
            if (head_ovf) begin
                sticky_ovf_d = 1'b1;
                if (ovf_cnt_d != 8'hFF) ovf_cnt_d = ovf_cnt_d + 8'd1;
            end
            if (head_carry) sticky_carry_d = 1'b1;
            if (head_zero != (head_d == '0)) err_zero_d = 1'b1;
        end
    end

    // Entry storage: written at wr_ptr on push, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.in_word;
        end
    end

    // Pointer, occupancy and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            ovf_cnt_q      <= 8'd0;
            err_zero_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
            ovf_cnt_q      <= ovf_cnt_d;
            err_zero_q     <= err_zero_d;
        end
    end
endmodule

// File: tb/tb_alu_status_reader.sv
// Directed bench for alu_status_reader: reset, fill/backpressure, streaming, zero check, saturation, reset mid-run.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_alu_status_reader;
    localparam int W = 32;
    localparam int D = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    alu_status_reader_if #(.width(W), .depth(D)) bus ();

    alu_status_reader #(.width(W), .depth(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+2:0] mk(input logic ovf, input logic zero, input logic carry,
                                        input logic [W-1:0] d);
        return {ovf, zero, carry, d};
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_word      = '0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.clear_sticky = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_out_d",     64'(bus.out_d),     64'd0);
        chk("rst_stats",     64'({bus.sticky_overflow, bus.sticky_carry, bus.err_zero, bus.ovf_count}), 64'd0);
        rst = 1'b0;
        step();

        // Single push {1,0,1,5} then one pop
        bus.in_word  = mk(1'b1, 1'b0, 1'b1, 32'h5);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("single_valid", 64'(bus.out_valid),    64'd1);
        chk("single_d",     64'(bus.out_d),        64'd5);
        chk("single_flags", 64'({bus.out_overflow, bus.out_zero, bus.out_carry}), 64'b101);
        chk("single_count", 64'(bus.count),        64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_count",    64'(bus.count),           64'd0);
        chk("pop_sticky",   64'({bus.sticky_overflow, bus.sticky_carry}), 64'b11);
        chk("pop_ovfcnt",   64'(bus.ovf_count),       64'd1);
        chk("pop_errzero",  64'(bus.err_zero),        64'd0);

        // Clear statistics
        bus.clear_sticky = 1'b1;
        step();
        bus.clear_sticky = 1'b0;
        chk("clear_stats", 64'({bus.sticky_overflow, bus.sticky_carry, bus.err_zero, bus.ovf_count}), 64'd0);

        // Fill four entries with backpressure
        for (int i = 0; i < 4; i++) begin
            bus.in_word  = mk(1'b0, 1'b0, 1'b0, 32'hA0 + 32'(i));
            bus.in_valid = 1'b1;
            step();
        end
        chk("fill_count",    64'(bus.count),    64'd4);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_word = mk(1'b0, 1'b0, 1'b0, 32'hA4);
        step();
        chk("held_count", 64'(bus.count), 64'd4);
        chk("held_head",  64'(bus.out_d), 64'hA0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop1_count",    64'(bus.count),    64'd3);
        chk("pop1_in_ready", 64'(bus.in_ready), 64'd1);
        chk("pop1_head",     64'(bus.out_d),    64'hA1);
        step();
        bus.in_valid = 1'b0;
        chk("accept5_count", 64'(bus.count), 64'd4);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_d",     64'(bus.out_d),     64'hA0 + 64'(i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Streaming d = 0..19 with out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_word = mk(1'b0, (i == 0), 1'b0, 32'(i));
            step();
            chk("stream_d",     64'(bus.out_d),     64'(i));
            chk("stream_count", 64'(bus.count),     64'd1);
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        chk("stream_end_count", 64'(bus.count),    64'd0);
        chk("stream_errzero",   64'(bus.err_zero), 64'd0);

        // Zero-flag consistency: {0,1,0,1} is inconsistent
        bus.in_word  = mk(1'b0, 1'b1, 1'b0, 32'h1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("errzero_set", 64'(bus.err_zero), 64'd1);
        bus.clear_sticky = 1'b1;
        step();
        bus.clear_sticky = 1'b0;
        chk("errzero_clr", 64'(bus.err_zero), 64'd0);
        bus.in_word  = mk(1'b0, 1'b1, 1'b0, 32'h0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("errzero_ok", 64'(bus.err_zero), 64'd0);

        // Saturate the overflow counter with 260 pops
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            bus.in_word = mk(1'b1, 1'b0, 1'b0, 32'(i + 1));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        chk("sat_ovfcnt", 64'(bus.ovf_count), 64'd255);
        chk("sat_count",  64'(bus.count),     64'd0);

        // Clear coincident with an overflow pop
        bus.in_word  = mk(1'b1, 1'b0, 1'b0, 32'h7);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.clear_sticky = 1'b1;
        step();
        bus.out_ready    = 1'b0;
        bus.clear_sticky = 1'b0;
        chk("clrpop_ovfcnt", 64'(bus.ovf_count),       64'd1);
        chk("clrpop_sticky", 64'(bus.sticky_overflow), 64'd1);
        chk("clrpop_carry",  64'(bus.sticky_carry),    64'd0);

        // Reset asserted with three entries held
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_word = mk(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(i));
            step();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_count", 64'(bus.count), 64'd3);
        rst = 1'b1;
        #1;
        chk("midrst_count",    64'(bus.count),     64'd0);
        chk("midrst_valid",    64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready),  64'd1);
        chk("midrst_out_d",    64'(bus.out_d),     64'd0);
        chk("midrst_stats", 64'({bus.sticky_overflow, bus.sticky_carry, bus.err_zero, bus.ovf_count}), 64'd0);
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
